// File: rtl/rsa_batch_seq_pkg.sv
// rsa_batch_seq_pkg
// Shared constants and types for the RSA batch sequencer slice.
//   DATA_WIDTH / MEMORY_ADDR_WIDTH : system-wide data and address widths
//   MEM_OP_READ / MEM_OP_WRITE     : encodings of the memory mem_op bit
//   seq_state_e                    : sequencer state encodings SEQ_IDLE .. SEQ_FIN
package rsa_batch_seq_pkg;

  localparam int DATA_WIDTH        = 16;
  localparam int MEMORY_ADDR_WIDTH = 8;

  localparam logic MEM_OP_READ  = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;

  typedef enum logic [3:0] {
    SEQ_IDLE,
    SEQ_LD_KEY,
    SEQ_LD_MOD,
    SEQ_LD_MSG,
    SEQ_RSA_CLR,
    SEQ_RSA_RUN,
    SEQ_ST_RES,
    SEQ_NEXT,
    SEQ_FIN
  } seq_state_e;

endpackage

// File: rtl/rsa_batch_seq_if.sv
// rsa_batch_seq_if
// Memory and RSA-core handshake bundle driven by the batch sequencer.
//   mem_en/mem_op/mem_rst/mem_addr/mem_datain : memory request (master -> slave)
//   mem_dataout/mem_ready                     : memory response (slave -> master)
//   rsa_en/rsa_rst/rsa_datain/rsa_keyin/rsa_modulusin : RSA start, clear, operands
//   rsa_dataout/rsa_ready                     : RSA response
// Modports: master = sequencer side, slave = memory/RSA side.
interface rsa_batch_seq_if;
  import rsa_batch_seq_pkg::*;

  logic                         mem_en;
  logic                         mem_op;
  logic                         mem_rst;
  logic [MEMORY_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]        mem_datain;
  logic [DATA_WIDTH-1:0]        mem_dataout;
  logic                         mem_ready;

  logic                         rsa_en;
  logic                         rsa_rst;
  logic [DATA_WIDTH-1:0]        rsa_datain;
  logic [DATA_WIDTH-1:0]        rsa_keyin;
  logic [DATA_WIDTH-1:0]        rsa_modulusin;
  logic [DATA_WIDTH-1:0]        rsa_dataout;
  logic                         rsa_ready;

  modport master (
    output mem_en, mem_op, mem_rst, mem_addr, mem_datain,
    input  mem_dataout, mem_ready,
    output rsa_en, rsa_rst, rsa_datain, rsa_keyin, rsa_modulusin,
    input  rsa_dataout, rsa_ready
  );

  modport slave (
    input  mem_en, mem_op, mem_rst, mem_addr, mem_datain,
    output mem_dataout, mem_ready,
    input  rsa_en, rsa_rst, rsa_datain, rsa_keyin, rsa_modulusin,
    output rsa_dataout, rsa_ready
  );

endinterface

// File: rtl/rsa_batch_seq_watchdog.sv
// seq_watchdog
// Loadable down-counter that flags a handshake wait lasting LOAD_VALUE cycles.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   run          : high while a handshake is waiting; low reloads the counter
//   expired      : high in the LOAD_VALUE-th consecutive cycle of run
module seq_watchdog #(
  parameter int unsigned LOAD_VALUE = 4096
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(LOAD_VALUE + 1);

  logic [CW-1:0] remaining;

  // Reloaded whenever the sequencer is not waiting, so each new wait starts
  // a fresh budget; parks at 1 so expired stays asserted until run drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      remaining <= '0;
    end else if (!run) begin
      remaining <= CW'(LOAD_VALUE);
    end else if (remaining > CW'(1)) begin
      remaining <= remaining - CW'(1);
    end
  end

  assign expired = run && (remaining == CW'(1));

endmodule

// File: rtl/rsa_batch_seq.sv
// rsa_batch_seq
// Autonomous sequencer: loads key and modulus once, then for each of `count`
// words reads src_addr+i, runs the RSA core and writes dst_addr+i.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   start, abort          : launch pulse (IDLE only) and synchronous cancel
//   key_addr, mod_addr, src_addr, dst_addr, count : batch setup, latched on start
//   busy, done, error     : status (done is a one-cycle pulse, error is sticky)
//   blocks_done           : results written so far in the current batch
//   bus                   : memory and RSA handshakes (rsa_batch_seq_if.master)
// Optional feature: define RSA_SEQ_TIMEOUT_EN to enable the handshake watchdog
// (TIMEOUT_CYCLES); without it waits are unbounded and error stays 0.
module rsa_batch_seq
  import rsa_batch_seq_pkg::*;
#(
  parameter int COUNT_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [MEMORY_ADDR_WIDTH-1:0] key_addr,
  input  logic [MEMORY_ADDR_WIDTH-1:0] mod_addr,
  input  logic [MEMORY_ADDR_WIDTH-1:0] src_addr,
  input  logic [MEMORY_ADDR_WIDTH-1:0] dst_addr,
  input  logic [COUNT_WIDTH-1:0]       count,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [COUNT_WIDTH-1:0]       blocks_done,
  rsa_batch_seq_if.master              bus
);

  seq_state_e state, next_state;

  logic [MEMORY_ADDR_WIDTH-1:0] key_addr_r, mod_addr_r, src_r, dst_r;
  logic [COUNT_WIDTH-1:0]       count_r, idx;
  logic [DATA_WIDTH-1:0]        key_r, mod_r, msg_r, res_r;
  logic                         gap, done_r, error_r;

  logic                         mem_state, mem_en_c, mem_done;
  logic                         rsa_en_c, rsa_done, waiting, timeout_hit, working;
  logic                         mem_op_c, rsa_rst_c;
  logic [MEMORY_ADDR_WIDTH-1:0] mem_addr_c;
  logic [DATA_WIDTH-1:0]        mem_datain_c;
  logic [COUNT_WIDTH-1:0]       idx_next;

  // gap blanks mem_en for one cycle after every completed transfer, which
  // gives both the "drop mem_en after ready" and "idle cycle between
  // back-to-back transfers" behaviour without extra states.
  assign mem_state = state inside {SEQ_LD_KEY, SEQ_LD_MOD, SEQ_LD_MSG, SEQ_ST_RES};
  assign mem_en_c  = mem_state && !gap;
  assign mem_done  = mem_en_c && bus.mem_ready;
  assign rsa_en_c  = (state == SEQ_RSA_RUN);
  assign rsa_done  = rsa_en_c && bus.rsa_ready;
  assign waiting   = (mem_en_c && !bus.mem_ready) || (rsa_en_c && !bus.rsa_ready);
  assign working   = state inside {SEQ_LD_KEY, SEQ_LD_MOD, SEQ_LD_MSG,
                                   SEQ_RSA_CLR, SEQ_RSA_RUN, SEQ_ST_RES};
  assign idx_next  = idx + COUNT_WIDTH'(1);

`ifdef RSA_SEQ_TIMEOUT_EN
  seq_watchdog #(
    .LOAD_VALUE (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .run     (waiting),
    .expired (timeout_hit)
  );
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^{waiting, 32'(TIMEOUT_CYCLES)};
`endif

  // State register plus the datapath registers that each state loads.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= SEQ_IDLE;
      key_addr_r  <= '0;
      mod_addr_r  <= '0;
      src_r       <= '0;
      dst_r       <= '0;
      count_r     <= '0;
      idx         <= '0;
      key_r       <= '0;
      mod_r       <= '0;
      msg_r       <= '0;
      res_r       <= '0;
      gap         <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      blocks_done <= '0;
    end else begin
      state  <= next_state;
      gap    <= mem_done;
      done_r <= (state == SEQ_FIN);
      case (state)
        SEQ_IDLE: begin
          if (start && !abort) begin
            key_addr_r  <= key_addr;
            mod_addr_r  <= mod_addr;
            src_r       <= src_addr;
            dst_r       <= dst_addr;
            count_r     <= count;
            idx         <= '0;
            blocks_done <= '0;
            error_r     <= 1'b0;
          end
        end
        SEQ_LD_KEY:  if (mem_done) key_r <= bus.mem_dataout;
        SEQ_LD_MOD:  if (mem_done) mod_r <= bus.mem_dataout;
        SEQ_LD_MSG:  if (mem_done) msg_r <= bus.mem_dataout;
        SEQ_RSA_RUN: if (rsa_done) res_r <= bus.rsa_dataout;
        SEQ_NEXT: begin
          // The write has already completed here, so it counts even if
          // abort arrives in this same cycle.
          idx         <= idx_next;
          blocks_done <= blocks_done + COUNT_WIDTH'(1);
        end
        default: ;
      endcase
      if (timeout_hit && working) begin
        error_r <= 1'b1;
      end
    end
  end

  // Next-state and per-state bus outputs; abort or timeout while working
  // lands in FIN so the enables fall in the very next cycle.
  always_comb begin
    next_state   = state;
    mem_op_c     = MEM_OP_READ;
    mem_addr_c   = '0;
    mem_datain_c = '0;
    rsa_rst_c    = 1'b0;
    case (state)
      SEQ_IDLE: begin
        if (start && !abort) begin
          next_state = (count == '0) ? SEQ_FIN : SEQ_LD_KEY;
        end
      end
      SEQ_LD_KEY: begin
        mem_addr_c = key_addr_r;
        if (mem_done) next_state = SEQ_LD_MOD;
      end
      SEQ_LD_MOD: begin
        mem_addr_c = mod_addr_r;
        if (mem_done) next_state = SEQ_LD_MSG;
      end
      SEQ_LD_MSG: begin
        mem_addr_c = src_r + MEMORY_ADDR_WIDTH'(idx);
        if (mem_done) next_state = SEQ_RSA_CLR;
      end
      SEQ_RSA_CLR: begin
        rsa_rst_c  = 1'b1;
        next_state = SEQ_RSA_RUN;
      end
      SEQ_RSA_RUN: begin
        if (rsa_done) next_state = SEQ_ST_RES;
      end
      SEQ_ST_RES: begin
        mem_op_c     = MEM_OP_WRITE;
        mem_addr_c   = dst_r + MEMORY_ADDR_WIDTH'(idx);
        mem_datain_c = res_r;
        if (mem_done) next_state = SEQ_NEXT;
      end
      SEQ_NEXT: begin
        next_state = (abort || idx_next == count_r) ? SEQ_FIN : SEQ_LD_MSG;
      end
      SEQ_FIN: begin
        next_state = SEQ_IDLE;
      end
      default: begin
        next_state = SEQ_IDLE;
      end
    endcase
    if (working && (abort || timeout_hit)) begin
      next_state = SEQ_FIN;
    end
  end

  assign bus.mem_en        = mem_en_c;
  assign bus.mem_op        = mem_op_c;
  assign bus.mem_rst       = 1'b0;
  assign bus.mem_addr      = mem_addr_c;
  assign bus.mem_datain    = mem_datain_c;
  assign bus.rsa_en        = rsa_en_c;
  assign bus.rsa_rst       = rsa_rst_c;
  assign bus.rsa_datain    = msg_r;
  assign bus.rsa_keyin     = key_r;
  assign bus.rsa_modulusin = mod_r;

  assign busy  = (state != SEQ_IDLE);
  assign done  = done_r;
  assign error = error_r;

endmodule

// File: tb/tb_rsa_batch_seq.sv
// tb_rsa_batch_seq
// Directed bench for rsa_batch_seq with a behavioural memory (programmable
// wait states) and a behavioural RSA core (fixed latency, optional stall).
// The timeout section runs only when RSA_SEQ_TIMEOUT_EN is defined.
module tb_rsa_batch_seq;
  import rsa_batch_seq_pkg::*;

  localparam int CW = 8;

  logic                         clock = 1'b0;
  logic                         reset, start, abort;
  logic [MEMORY_ADDR_WIDTH-1:0] key_addr, mod_addr, src_addr, dst_addr;
  logic [CW-1:0]                count;
  logic                         busy, done, error;
  logic [CW-1:0]                blocks_done;

  rsa_batch_seq_if bus ();

  rsa_batch_seq #(
    .COUNT_WIDTH    (CW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .key_addr    (key_addr),
    .mod_addr    (mod_addr),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .blocks_done (blocks_done),
    .bus         (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Memory model: answers after mem_delay extra cycles, preloaded via load_*.
  logic [DATA_WIDTH-1:0]        mem [256];
  int                           mem_delay = 0;
  int                           mem_wait;
  logic                         load_en = 1'b0;
  logic [MEMORY_ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0]        load_data;

  always @(posedge clock) begin
    if (load_en) mem[load_addr] <= load_data;
    if (reset) begin
      bus.mem_ready   <= 1'b0;
      bus.mem_dataout <= '0;
      mem_wait        <= 0;
    end else if (bus.mem_en && !bus.mem_ready) begin
      if (mem_wait >= mem_delay) begin
        bus.mem_ready <= 1'b1;
        mem_wait      <= 0;
        if (bus.mem_op) mem[bus.mem_addr] <= bus.mem_datain;
        else            bus.mem_dataout   <= mem[bus.mem_addr];
      end else begin
        mem_wait <= mem_wait + 1;
      end
    end else begin
      bus.mem_ready <= 1'b0;
      mem_wait      <= 0;
    end
  end

  // RSA model: result = data^key mod modulus after four enabled cycles.
  logic rsa_stall = 1'b0;
  int   rsa_cnt;

  function automatic logic [DATA_WIDTH-1:0] modexp(input logic [DATA_WIDTH-1:0] b,
                                                   input logic [DATA_WIDTH-1:0] e,
                                                   input logic [DATA_WIDTH-1:0] m);
    logic [31:0] r, x;
    if (m == '0) return '0;
    r = 32'd1 % m;
    x = b % m;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      if (e[k]) r = (r * x) % m;
      x = (x * x) % m;
    end
    return r[DATA_WIDTH-1:0];
  endfunction

  always @(posedge clock) begin
    if (reset || bus.rsa_rst) begin
      bus.rsa_ready   <= 1'b0;
      bus.rsa_dataout <= '0;
      rsa_cnt         <= 0;
    end else if (bus.rsa_en && !bus.rsa_ready) begin
      if (!rsa_stall) begin
        if (rsa_cnt >= 3) begin
          bus.rsa_ready   <= 1'b1;
          bus.rsa_dataout <= modexp(bus.rsa_datain, bus.rsa_keyin, bus.rsa_modulusin);
        end else begin
          rsa_cnt <= rsa_cnt + 1;
        end
      end
    end else if (!bus.rsa_en) begin
      bus.rsa_ready <= 1'b0;
    end
  end

  // Monitor: monotonic event counters plus memory-protocol violation counts.
  int                           done_cnt = 0, mem_en_cnt = 0, rsa_en_cnt = 0;
  int                           hold_viol = 0, gap_viol = 0;
  logic [MEMORY_ADDR_WIDTH-1:0] read_log [$];
  logic                         prev_en = 1'b0, prev_ready = 1'b0, prev_op = 1'b0;
  logic [MEMORY_ADDR_WIDTH-1:0] prev_addr = '0;
  logic [DATA_WIDTH-1:0]        prev_datain = '0;

  always @(negedge clock) begin
    if (done)        done_cnt   <= done_cnt + 1;
    if (bus.mem_en)  mem_en_cnt <= mem_en_cnt + 1;
    if (bus.rsa_en)  rsa_en_cnt <= rsa_en_cnt + 1;
    if (bus.mem_en && bus.mem_ready && !bus.mem_op) read_log.push_back(bus.mem_addr);
    if (!reset && prev_en && !prev_ready &&
        (!bus.mem_en || bus.mem_addr != prev_addr || bus.mem_op != prev_op ||
         bus.mem_datain != prev_datain))
      hold_viol <= hold_viol + 1;
    if (!reset && prev_en && prev_ready && bus.mem_en)
      gap_viol <= gap_viol + 1;
    prev_en     <= bus.mem_en;
    prev_ready  <= bus.mem_ready;
    prev_op     <= bus.mem_op;
    prev_addr   <= bus.mem_addr;
    prev_datain <= bus.mem_datain;
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic load_word(input logic [MEMORY_ADDR_WIDTH-1:0] a,
                           input logic [DATA_WIDTH-1:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic launch(input logic [MEMORY_ADDR_WIDTH-1:0] k, m, s, d,
                        input logic [CW-1:0] n);
    key_addr = k;
    mod_addr = m;
    src_addr = s;
    dst_addr = d;
    count    = n;
    start    = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < limit && !seen; c++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation did not terminate");
  end

  initial begin
    int base_done, base_men, base_ren, base_rd;
    logic found;
    reset = 1'b1; start = 1'b0; abort = 1'b0; count = '0;
    key_addr = '0; mod_addr = '0; src_addr = '0; dst_addr = '0;
    repeat (3) tick();

    // Reset values
    check("reset busy",        32'(busy),            32'd0);
    check("reset done",        32'(done),            32'd0);
    check("reset error",       32'(error),           32'd0);
    check("reset blocks_done", 32'(blocks_done),     32'd0);
    check("reset mem_en",      32'(bus.mem_en),      32'd0);
    check("reset rsa_en",      32'(bus.rsa_en),      32'd0);
    check("reset mem_addr",    32'(bus.mem_addr),    32'd0);
    check("reset rsa_keyin",   32'(bus.rsa_keyin),   32'd0);

    load_word(8'h00, 16'd3);
    load_word(8'h01, 16'd33);
    load_word(8'h10, 16'd2);
    load_word(8'h11, 16'd4);
    load_word(8'h12, 16'd5);
    load_word(8'h13, 16'd7);
    load_word(8'hFF, 16'd2);
    for (int a = 8'h30; a < 8'h34; a++) load_word(8'(a), 16'hDEAD);
    reset = 1'b0;
    tick();

    // Basic batch, zero-wait memory
    base_done = done_cnt; base_men = mem_en_cnt;
    launch(8'h00, 8'h01, 8'h10, 8'h20, 8'd3);
    wait_done(2000, "basic done seen");
    check("basic mem[0x20]",    32'(mem[8'h20]),        32'd8);
    check("basic mem[0x21]",    32'(mem[8'h21]),        32'd31);
    check("basic mem[0x22]",    32'(mem[8'h22]),        32'd26);
    check("basic done pulses",  32'(done_cnt - base_done), 32'd1);
    check("basic blocks_done",  32'(blocks_done),       32'd3);
    check("basic busy idle",    32'(busy),              32'd0);
    check("basic rsa_keyin",    32'(bus.rsa_keyin),     32'd3);
    check("basic rsa_modulus",  32'(bus.rsa_modulusin), 32'd33);
    check("basic mem_en cycles", 32'(mem_en_cnt - base_men), 32'd16);

    // count = 0: done two cycles after start, no accesses
    base_men = mem_en_cnt; base_ren = rsa_en_cnt;
    launch(8'h00, 8'h01, 8'h10, 8'h70, 8'd0);
    check("cnt0 busy +1",  32'(busy), 32'd1);
    check("cnt0 done +1",  32'(done), 32'd0);
    tick();
    check("cnt0 done +2",  32'(done), 32'd1);
    tick();
    check("cnt0 done +3",  32'(done), 32'd0);
    check("cnt0 busy +3",  32'(busy), 32'd0);
    repeat (2) tick();
    check("cnt0 mem_en never", 32'(mem_en_cnt - base_men), 32'd0);
    check("cnt0 rsa_en never", 32'(rsa_en_cnt - base_ren), 32'd0);

    // Source address wraps from 0xFF to 0x00
    base_rd = read_log.size();
    launch(8'h00, 8'h01, 8'hFF, 8'h40, 8'd2);
    wait_done(2000, "wrap done seen");
    check("wrap read count",  32'(read_log.size() - base_rd), 32'd4);
    check("wrap first msg",   32'(read_log[base_rd + 2]), 32'hFF);
    check("wrap second msg",  32'(read_log[base_rd + 3]), 32'h00);
    check("wrap mem[0x40]",   32'(mem[8'h40]), 32'd8);
    check("wrap mem[0x41]",   32'(mem[8'h41]), 32'd27);

    // Five wait states per transfer; a start while busy must be ignored
    mem_delay = 5;
    base_men = mem_en_cnt;
    launch(8'h00, 8'h01, 8'h10, 8'h50, 8'd3);
    repeat (3) tick();
    src_addr = 8'h00; dst_addr = 8'h60; count = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(3000, "delay done seen");
    check("delay mem[0x50]",     32'(mem[8'h50]), 32'd8);
    check("delay mem[0x51]",     32'(mem[8'h51]), 32'd31);
    check("delay mem[0x52]",     32'(mem[8'h52]), 32'd26);
    check("delay mem_en cycles", 32'(mem_en_cnt - base_men), 32'd56);
    check("delay blocks_done",   32'(blocks_done), 32'd3);
    check("hold violations",     32'(hold_viol), 32'd0);
    check("gap violations",      32'(gap_viol),  32'd0);
    mem_delay = 0;

    // Abort while word 1 is in the RSA core
    base_done = done_cnt;
    launch(8'h00, 8'h01, 8'h10, 8'h30, 8'd4);
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      if (bus.rsa_en && blocks_done == 8'd1) found = 1'b1;
      else tick();
    end
    check("abort reached word1 rsa", 32'(found), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort rsa_en drop", 32'(bus.rsa_en), 32'd0);
    check("abort mem_en low",  32'(bus.mem_en), 32'd0);
    tick();
    check("abort done pulse",  32'(done), 32'd1);
    repeat (3) tick();
    check("abort blocks_done", 32'(blocks_done), 32'd1);
    check("abort done count",  32'(done_cnt - base_done), 32'd1);
    check("abort mem[0x30]",   32'(mem[8'h30]), 32'd8);
    check("abort mem[0x31]",   32'(mem[8'h31]), 32'hDEAD);

    // abort and start together in IDLE: nothing launches
    base_done = done_cnt; base_men = mem_en_cnt;
    abort = 1'b1;
    launch(8'h00, 8'h01, 8'h10, 8'h30, 8'd2);
    abort = 1'b0;
    check("abort+start busy", 32'(busy), 32'd0);
    repeat (4) tick();
    check("abort+start no done",   32'(done_cnt - base_done), 32'd0);
    check("abort+start no mem_en", 32'(mem_en_cnt - base_men), 32'd0);

`ifdef RSA_SEQ_TIMEOUT_EN
    // RSA core never answers: watchdog ends the batch after 16 wait cycles
    rsa_stall = 1'b1;
    base_ren = rsa_en_cnt; base_done = done_cnt;
    launch(8'h00, 8'h01, 8'h10, 8'h60, 8'd1);
    wait_done(500, "timeout done seen");
    check("timeout error set",   32'(error), 32'd1);
    check("timeout rsa_en cycles", 32'(rsa_en_cnt - base_ren), 32'd16);
    check("timeout blocks_done", 32'(blocks_done), 32'd0);
    rsa_stall = 1'b0;
    launch(8'h00, 8'h01, 8'h10, 8'h60, 8'd0);
    check("timeout error cleared", 32'(error), 32'd0);
    repeat (3) tick();
`endif

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
